// File: rtl/sram_axi_arb.sv
// sram_axi_arb: two-master arbiter in front of a single simplified AXI SRAM port.
//
// Ports
//   clk, rst_n                : single clock, asynchronous active-low reset
//   m0_axi_* / m1_axi_*       : master-side AW, W, AR and R channels (no B channel)
//   s_axi_*                   : slave-side mirror toward the SRAM
// Parameters
//   ADDR_W : address width of all AW/AR channels
//   RR_EN  : 1 = round-robin between masters, 0 = fixed priority (m0 wins)
//
// One transaction is in flight at a time. Writes complete in the single cycle
// where the SRAM accepts both AW and W. Reads hold the arbiter in RD_WAIT until
// the R handshake so that the R channel can be routed back to its owner.
module sram_axi_arb #(
    parameter int ADDR_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_axi_awaddr,
    input  logic              m0_axi_awvalid,
    output logic              m0_axi_awready,
    input  logic [31:0]       m0_axi_wdata,
    input  logic [3:0]        m0_axi_wstrb,
    input  logic              m0_axi_wvalid,
    output logic              m0_axi_wready,
    input  logic [ADDR_W-1:0] m0_axi_araddr,
    input  logic              m0_axi_arvalid,
    output logic              m0_axi_arready,
    output logic [31:0]       m0_axi_rdata,
    output logic              m0_axi_rvalid,
    input  logic              m0_axi_rready,

    input  logic [ADDR_W-1:0] m1_axi_awaddr,
    input  logic              m1_axi_awvalid,
    output logic              m1_axi_awready,
    input  logic [31:0]       m1_axi_wdata,
    input  logic [3:0]        m1_axi_wstrb,
    input  logic              m1_axi_wvalid,
    output logic              m1_axi_wready,
    input  logic [ADDR_W-1:0] m1_axi_araddr,
    input  logic              m1_axi_arvalid,
    output logic              m1_axi_arready,
    output logic [31:0]       m1_axi_rdata,
    output logic              m1_axi_rvalid,
    input  logic              m1_axi_rready,

    output logic [ADDR_W-1:0] s_axi_awaddr,
    output logic              s_axi_awvalid,
    input  logic              s_axi_awready,
    output logic [31:0]       s_axi_wdata,
    output logic [3:0]        s_axi_wstrb,
    output logic              s_axi_wvalid,
    input  logic              s_axi_wready,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    input  logic [31:0]       s_axi_rdata,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready
);

    localparam bit RR = (RR_EN != 0);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t state_reg;
    logic   rd_owner_reg;
    logic   prio_reg;

    // Master inputs gathered into arrays so the datapath can index by grant.
    logic [ADDR_W-1:0] awaddr_m [2];
    logic [31:0]       wdata_m  [2];
    logic [3:0]        wstrb_m  [2];
    logic [ADDR_W-1:0] araddr_m [2];
    logic [1:0]        awvalid_m, wvalid_m, arvalid_m, rready_m;
    logic [1:0]        awready_m, wready_m, arready_m, rvalid_m;

    assign awaddr_m[0] = m0_axi_awaddr;
    assign awaddr_m[1] = m1_axi_awaddr;
    assign wdata_m[0]  = m0_axi_wdata;
    assign wdata_m[1]  = m1_axi_wdata;
    assign wstrb_m[0]  = m0_axi_wstrb;
    assign wstrb_m[1]  = m1_axi_wstrb;
    assign araddr_m[0] = m0_axi_araddr;
    assign araddr_m[1] = m1_axi_araddr;
    assign awvalid_m   = {m1_axi_awvalid, m0_axi_awvalid};
    assign wvalid_m    = {m1_axi_wvalid,  m0_axi_wvalid};
    assign arvalid_m   = {m1_axi_arvalid, m0_axi_arvalid};
    assign rready_m    = {m1_axi_rready,  m0_axi_rready};

    logic [1:0] wreq, rreq, req;
    logic       win1;
    logic [1:0] gnt_oh;
    logic       gsel;
    logic       g_wr, g_rd;
    logic       wr_done, ar_done;
    logic       rd_active;
    logic [1:0] owner_oh;

    assign wreq = awvalid_m & wvalid_m;
    assign rreq = arvalid_m;

    // Requests only count while idle and out of reset; this also forces every
    // output low during reset. Grant uses valids and prio only, never readys.
    assign req  = (wreq | rreq) & {2{rst_n && (state_reg == IDLE)}};
    assign win1 = req[1] & (~req[0] | (RR & prio_reg));
    assign gnt_oh = {win1, req[0] & ~win1};
    assign gsel   = win1;

    // Write beats read inside the granted master.
    assign g_wr = (|gnt_oh) & wreq[gsel];
    assign g_rd = (|gnt_oh) & ~wreq[gsel] & rreq[gsel];

    assign wr_done = g_wr & s_axi_awready & s_axi_wready;
    assign ar_done = g_rd & s_axi_arready;

    assign rd_active = (state_reg == RD_WAIT);
    assign owner_oh  = {rd_owner_reg, ~rd_owner_reg};

    always_comb begin
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        if (g_wr) begin
            s_axi_awaddr  = awaddr_m[gsel];
            s_axi_awvalid = 1'b1;
            s_axi_wdata   = wdata_m[gsel];
            s_axi_wstrb   = wstrb_m[gsel];
            s_axi_wvalid  = 1'b1;
        end
        if (g_rd) begin
            s_axi_araddr  = araddr_m[gsel];
            s_axi_arvalid = 1'b1;
        end
    end

    assign s_axi_rready = rd_active & rready_m[rd_owner_reg];

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign awready_m[gi] = g_wr & gnt_oh[gi] & s_axi_awready;
        assign wready_m[gi]  = g_wr & gnt_oh[gi] & s_axi_wready;
        assign arready_m[gi] = g_rd & gnt_oh[gi] & s_axi_arready;
        assign rvalid_m[gi]  = rd_active & owner_oh[gi] & s_axi_rvalid;
    end

    assign m0_axi_awready = awready_m[0];
    assign m0_axi_wready  = wready_m[0];
    assign m0_axi_arready = arready_m[0];
    assign m0_axi_rvalid  = rvalid_m[0];
    assign m0_axi_rdata   = s_axi_rdata;
    assign m1_axi_awready = awready_m[1];
    assign m1_axi_wready  = wready_m[1];
    assign m1_axi_arready = arready_m[1];
    assign m1_axi_rvalid  = rvalid_m[1];
    assign m1_axi_rdata   = s_axi_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rd_owner_reg <= 1'b0;
            prio_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ar_done) begin
                        state_reg    <= RD_WAIT;
                        rd_owner_reg <= gsel;
                    end
                    // Only completed handshakes move the fairness pointer.
                    if (RR && (wr_done || ar_done)) begin
                        prio_reg <= ~gsel;
                    end
                end
                RD_WAIT: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_arb.sv
`timescale 1ns/1ps
module tb_sram_axi_arb;

    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
        logic [1:0]  awready;
        logic [1:0]  wready;
        logic [1:0]  arready;
        logic [1:0]  rvalid;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
    } obs_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
    } slv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        slv_rand;
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        rready  [2];

    obs_t obs [2];
    slv_t slv [2];

    int errors = 0;
    int checks = 0;

    // Instance 0 runs round-robin, instance 1 fixed priority; both see the same masters.
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
        logic [3:0]  s_wstrb;
        logic        s_awvalid, s_wvalid, s_arvalid, s_rready;
        logic        s_awready, s_wready, s_arready, s_rvalid;
        logic        m0_awready, m0_wready, m0_arready, m0_rvalid;
        logic        m1_awready, m1_wready, m1_arready, m1_rvalid;
        logic [31:0] m0_rdata, m1_rdata;

        sram_axi_arb #(.ADDR_W(32), .RR_EN(gi == 0 ? 1 : 0)) dut (
            .clk(clk), .rst_n(rst_n),
            .m0_axi_awaddr(awaddr[0]), .m0_axi_awvalid(awvalid[0]), .m0_axi_awready(m0_awready),
            .m0_axi_wdata(wdata[0]), .m0_axi_wstrb(wstrb[0]), .m0_axi_wvalid(wvalid[0]),
            .m0_axi_wready(m0_wready), .m0_axi_araddr(araddr[0]), .m0_axi_arvalid(arvalid[0]),
            .m0_axi_arready(m0_arready), .m0_axi_rdata(m0_rdata), .m0_axi_rvalid(m0_rvalid),
            .m0_axi_rready(rready[0]),
            .m1_axi_awaddr(awaddr[1]), .m1_axi_awvalid(awvalid[1]), .m1_axi_awready(m1_awready),
            .m1_axi_wdata(wdata[1]), .m1_axi_wstrb(wstrb[1]), .m1_axi_wvalid(wvalid[1]),
            .m1_axi_wready(m1_wready), .m1_axi_araddr(araddr[1]), .m1_axi_arvalid(arvalid[1]),
            .m1_axi_arready(m1_arready), .m1_axi_rdata(m1_rdata), .m1_axi_rvalid(m1_rvalid),
            .m1_axi_rready(rready[1]),
            .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
            .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid),
            .s_axi_wready(s_wready), .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid),
            .s_axi_arready(s_arready), .s_axi_rdata(s_rdata), .s_axi_rvalid(s_rvalid),
            .s_axi_rready(s_rready)
        );

        // Simple SRAM slave sharing rst_n: random readiness and 0..2 cycle read latency.
        logic [31:0] mem [0:255];
        logic        rdy_reg, busy_reg;
        logic [7:0]  idx_reg;
        logic [1:0]  cnt_reg;

        initial for (int k = 0; k < 256; k++) mem[k] = 32'h0;

        assign s_awready = rdy_reg;
        assign s_wready  = rdy_reg;
        assign s_arready = rdy_reg & ~busy_reg;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdy_reg  <= 1'b0;
                busy_reg <= 1'b0;
                idx_reg  <= 8'h0;
                cnt_reg  <= 2'd0;
                s_rvalid <= 1'b0;
                s_rdata  <= 32'h0;
            end else begin
                rdy_reg <= slv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (s_awvalid && s_wvalid && s_awready && s_wready) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[9:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
                end
                if (s_arvalid && s_arready) begin
                    busy_reg <= 1'b1;
                    idx_reg  <= s_araddr[9:2];
                    cnt_reg  <= slv_rand ? 2'($urandom_range(0, 2)) : 2'd0;
                end else if (busy_reg && !s_rvalid) begin
                    if (cnt_reg == 2'd0) begin
                        s_rvalid <= 1'b1;
                        s_rdata  <= mem[idx_reg];
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end else if (s_rvalid && s_rready) begin
                    s_rvalid <= 1'b0;
                    busy_reg <= 1'b0;
                end
            end
        end

        assign obs[gi] = {s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_araddr, s_arvalid,
                          s_rready, {m1_awready, m0_awready}, {m1_wready, m0_wready},
                          {m1_arready, m0_arready}, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata};
        assign slv[gi] = {s_awready, s_wready, s_arready, s_rvalid, s_rdata};
    end

    // ---------------- behavioural model ----------------
    logic        busy_m  [2];
    logic        owner_m [2];
    logic        prio_m  [2];
    logic [7:0]  rdidx_m [2];
    logic [31:0] shadow  [2][256];
    int          glog0 [$];   // observed AR grants, round-robin instance
    int          glog1 [$];   // observed AR grants, fixed-priority instance

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int winner(input int i);
        logic [1:0] r;
        for (int n = 0; n < 2; n++) r[n] = (awvalid[n] & wvalid[n]) | arvalid[n];
        if (r == 2'b00) return -1;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (i == 0) ? int'(prio_m[i]) : 0;
    endfunction

    task automatic model_step(input int i);
        obs_t e;
        slv_t s;
        int   w;
        s = slv[i];
        e = '0;
        e.rdata0 = s.rdata;
        e.rdata1 = s.rdata;
        w = -1;
        if (rst_n) begin
            if (busy_m[i]) begin
                e.rready = rready[owner_m[i]];
                e.rvalid[owner_m[i]] = s.rvalid;
            end else begin
                w = winner(i);
                if (w >= 0) begin
                    if (awvalid[w] && wvalid[w]) begin
                        e.awaddr = awaddr[w];
                        e.awvalid = 1'b1;
                        e.wdata = wdata[w];
                        e.wstrb = wstrb[w];
                        e.wvalid = 1'b1;
                        e.awready[w] = s.awready;
                        e.wready[w] = s.wready;
                    end else begin
                        e.araddr = araddr[w];
                        e.arvalid = 1'b1;
                        e.arready[w] = s.arready;
                    end
                end
            end
        end
        chk($sformatf("s_aw_w[%0d]", i),
            256'({obs[i].awaddr, obs[i].awvalid, obs[i].wdata, obs[i].wstrb, obs[i].wvalid}),
            256'({e.awaddr, e.awvalid, e.wdata, e.wstrb, e.wvalid}));
        chk($sformatf("s_ar_r[%0d]", i),
            256'({obs[i].araddr, obs[i].arvalid, obs[i].rready}),
            256'({e.araddr, e.arvalid, e.rready}));
        chk($sformatf("m0_side[%0d]", i),
            256'({obs[i].awready[0], obs[i].wready[0], obs[i].arready[0], obs[i].rvalid[0], obs[i].rdata0}),
            256'({e.awready[0], e.wready[0], e.arready[0], e.rvalid[0], e.rdata0}));
        chk($sformatf("m1_side[%0d]", i),
            256'({obs[i].awready[1], obs[i].wready[1], obs[i].arready[1], obs[i].rvalid[1], obs[i].rdata1}),
            256'({e.awready[1], e.wready[1], e.arready[1], e.rvalid[1], e.rdata1}));

        if (rst_n && obs[i].arvalid && (|obs[i].arready)) begin
            if (i == 0) glog0.push_back(int'(obs[i].arready[1]));
            else        glog1.push_back(int'(obs[i].arready[1]));
        end

        if (!rst_n) begin
            busy_m[i] = 1'b0;
            owner_m[i] = 1'b0;
            prio_m[i] = 1'b0;
        end else if (busy_m[i]) begin
            if (s.rvalid && rready[owner_m[i]]) begin
                chk($sformatf("rd_data[%0d]", i), 256'(s.rdata), 256'(shadow[i][rdidx_m[i]]));
                busy_m[i] = 1'b0;
            end
        end else if (w >= 0) begin
            if (awvalid[w] && wvalid[w]) begin
                if (s.awready && s.wready) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[w][b]) shadow[i][awaddr[w][9:2]][b*8 +: 8] = wdata[w][b*8 +: 8];
                    if (i == 0) prio_m[i] = (w == 0);
                end
            end else if (s.arready) begin
                busy_m[i] = 1'b1;
                owner_m[i] = (w == 1);
                rdidx_m[i] = araddr[w][9:2];
                if (i == 0) prio_m[i] = (w == 0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            awaddr[n] = '0; awvalid[n] = 1'b0; wdata[n] = '0; wstrb[n] = '0; wvalid[n] = 1'b0;
            araddr[n] = '0; arvalid[n] = 1'b0; rready[n] = 1'b0;
        end
    endtask

    // Waits at negedges for instance 0's rvalid toward master m, bounded.
    task automatic wait_rv(input int m, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (obs[0].rvalid[m] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rvalid_timeout"}, 256'(n >= 20), 256'(0));
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL global_timeout at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int bad, cnt1;
        rst_n = 1'b0;
        slv_rand = 1'b0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            busy_m[i] = 1'b0; owner_m[i] = 1'b0; prio_m[i] = 1'b0; rdidx_m[i] = 8'h0;
            for (int k = 0; k < 256; k++) shadow[i][k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_zero_rr", 256'(obs[0]), 256'(0));
        chk("reset_zero_fixed", 256'(obs[1]), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // m0 write then m1 read back
        awaddr[0] = 32'h10; wdata[0] = 32'hA5A5A5A5; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        chk("t1_s_aw", 256'({obs[0].awvalid, obs[0].wvalid, obs[0].awaddr, obs[0].wdata, obs[0].wstrb}),
            256'({1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF}));
        chk("t1_m0_ready", 256'({obs[0].awready, obs[0].wready}), 256'(4'b0101));
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        araddr[1] = 32'h10; arvalid[1] = 1'b1; rready[1] = 1'b1;
        @(negedge clk);
        chk("t1_m1_ar", 256'({obs[0].arvalid, obs[0].araddr, obs[0].arready}), 256'({1'b1, 32'h10, 2'b10}));
        tick();
        arvalid[1] = 1'b0;
        wait_rv(1, "t1");
        chk("t1_rd_data", 256'(obs[0].rdata1), 256'(32'hA5A5A5A5));
        chk("t1_rvalid_owner", 256'(obs[0].rvalid), 256'(2'b10));
        tick();
        rready[1] = 1'b0;

        // contention: both masters read continuously
        glog0.delete();
        glog1.delete();
        araddr[0] = 32'h20; araddr[1] = 32'h24;
        arvalid[0] = 1'b1; arvalid[1] = 1'b1; rready[0] = 1'b1; rready[1] = 1'b1;
        repeat (24) tick();
        arvalid[0] = 1'b0; arvalid[1] = 1'b0;
        repeat (5) tick();
        rready[0] = 1'b0; rready[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < glog0.size(); k++) if (glog0[k] != k % 2) bad++;
        chk("t2_rr_alternate", 256'(bad), 256'(0));
        chk("t2_rr_enough_grants", 256'(glog0.size() >= 6), 256'(1));
        cnt1 = 0;
        for (int k = 0; k < glog1.size(); k++) if (glog1[k] == 1) cnt1++;
        chk("t2_fixed_m1_never", 256'(cnt1), 256'(0));
        chk("t2_fixed_m0_served", 256'(glog1.size() >= 6), 256'(1));

        // m0 read stalled by rready=0 while m1 wants to write
        araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0;
        @(negedge clk);
        chk("t3_m0_ar", 256'(obs[0].arready), 256'(2'b01));
        tick();
        arvalid[0] = 1'b0;
        awaddr[1] = 32'h30; wdata[1] = 32'h12345678; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t3_m1_wready_held_%0d", k), 256'({obs[0].wready[1], obs[0].awvalid}), 256'(0));
            tick();
        end
        rready[0] = 1'b1;
        @(negedge clk);
        chk("t3_m0_rvalid", 256'({obs[0].rvalid, obs[0].rdata0}), 256'({2'b01, 32'hA5A5A5A5}));
        tick();
        @(negedge clk);
        chk("t3_m1_granted", 256'({obs[0].wready[1], obs[0].awaddr}), 256'({1'b1, 32'h30}));
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0; rready[0] = 1'b0;

        // m1 write+read together, partial strobe
        awaddr[0] = 32'h40; wdata[0] = 32'h11223344; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        awaddr[1] = 32'h40; wdata[1] = 32'hAABBCCDD; wstrb[1] = 4'h3;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1; araddr[1] = 32'h40; arvalid[1] = 1'b1; rready[1] = 1'b1;
        @(negedge clk);
        chk("t4_write_first", 256'({obs[0].awvalid, obs[0].arvalid, obs[0].wstrb, obs[0].wready}),
            256'({1'b1, 1'b0, 4'h3, 2'b10}));
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        @(negedge clk);
        chk("t4_read_after", 256'({obs[0].arvalid, obs[0].araddr, obs[0].arready}), 256'({1'b1, 32'h40, 2'b10}));
        tick();
        arvalid[1] = 1'b0;
        wait_rv(1, "t4");
        chk("t4_merged", 256'(obs[0].rdata1), 256'(32'h1122CCDD));
        tick();
        rready[1] = 1'b0;

        // reset during RD_WAIT
        araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0;
        tick();
        arvalid[0] = 1'b0;
        araddr[1] = 32'h44; arvalid[1] = 1'b1; rready[1] = 1'b1;
        @(negedge clk);
        tick();
        chk("t5_in_rd_wait", 256'({obs[0].rvalid, obs[0].arready, obs[0].arvalid}), 256'({2'b01, 2'b00, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_zero_rr", 256'(obs[0]), 256'(0));
        chk("t5_async_zero_fixed", 256'(obs[1]), 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_m1_granted", 256'({obs[0].arvalid, obs[0].araddr, obs[0].rvalid}), 256'({1'b1, 32'h44, 2'b00}));
        wait_rv(1, "t5");
        chk("t5_rd_data", 256'(obs[0].rdata1), 256'(0));
        tick();
        clear_inputs();
        tick();

        // randomized traffic
        slv_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                awvalid[n] = 1'($urandom_range(0, 1));
                wvalid[n]  = ($urandom_range(0, 3) != 0);
                arvalid[n] = 1'($urandom_range(0, 1));
                rready[n]  = ($urandom_range(0, 3) != 0);
                awaddr[n]  = 32'($urandom_range(0, 7)) << 2;
                araddr[n]  = 32'($urandom_range(0, 7)) << 2;
                wdata[n]   = $urandom;
                wstrb[n]   = 4'($urandom_range(0, 15));
            end
        end
        tick();
        clear_inputs();
        rready[0] = 1'b1; rready[1] = 1'b1;
        slv_rand = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_axi_arb.md
SRAM_AXI_ARB -- requirements
Module: sram_axi_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the address width of all AW/AR channels; it equals the `MemAddrBus width.
REQ-002 SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with m0 always winning.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  master 0 write address channel.
REQ-006 m0_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  master 0 write data channel.
REQ-007 m0_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  master 0 read address channel.
REQ-008 m0_axi_rdata/rvalid/rready  out/out/in  32/1/1  master 0 read data channel.
REQ-009 m1_axi_* SHALL be an identical set of ports (REQ-005..008) for master 1.
REQ-010 s_axi_* SHALL be the mirrored set of ports (aw*, w*, ar* out; awready, wready, arready, rdata, rvalid in; rready out) toward the SRAM slave.

Function
REQ-011 Write request of master n: wreq_n = awvalid & wvalid. Read request: rreq_n = arvalid. Master n requests when wreq_n | rreq_n.
REQ-012 FSM states: IDLE and RD_WAIT. Registers: state, rd_owner (1 bit), prio (1 bit; the master favoured on the next contention).
REQ-013 In IDLE, grant is combinational from the valid inputs and prio only; grant SHALL NOT depend on any ready input, so no combinational loop exists.
REQ-014 Grant rule: only one master requesting -> that master; both requesting -> master prio when RR_EN=1, master 0 when RR_EN=0.
REQ-015 Within the granted master, a write SHALL take precedence over a read in the same cycle; the read waits for a later cycle.
REQ-016 Granted write: drive that master's awaddr, wdata, wstrb, awvalid and wvalid to s_axi; return s_axi_awready/wready to that master only.
REQ-017 Granted write timing: a write completes in the cycle s_awready & s_wready = 1; the FSM stays in IDLE.
REQ-018 Granted read: drive that master's araddr and arvalid to s_axi. On s_arready=1: state <= RD_WAIT, rd_owner <= granted master.
REQ-019 In RD_WAIT: route s_rdata/s_rvalid to the rd_owner master and that master's rready to s_rready; the other master sees rvalid=0.
REQ-020 In RD_WAIT, all s_axi valids SHALL be 0 and all master aw/w/ar readys SHALL be 0; there is no read pipelining.
REQ-021 RD_WAIT exit: on s_rvalid & s_rready, state <= IDLE; a new grant is allowed in the following cycle.
REQ-022 prio update: when RR_EN=1, prio <= ~granted master on every completed write handshake or AR handshake; prio is otherwise unchanged.
REQ-023 Non-granted master, and all masters when no request is pending: all readys=0, rvalid=0; s_axi valids=0, addresses/data/strobes=0.
REQ-024 m0_axi_rdata and m1_axi_rdata SHALL both equal s_axi_rdata at all times; the respective rvalid qualifies the data.
REQ-025 A master that deasserts valid before its handshake loses the grant without side effect; prio is not updated.

Reset
REQ-026 On rst_n=0, state SHALL go to IDLE, rd_owner to 0 and prio to 0 immediately, independent of clk.
REQ-027 During reset, all outputs SHALL be 0 as a consequence of REQ-023.
REQ-028 Reset asserted during RD_WAIT SHALL abandon the read; the SRAM slave shares rst_n, so no stale s_rvalid follows.
REQ-029 First edge after rst_n deasserts: normal arbitration with m0 favoured.

Verification
REQ-030 Bench SHALL cover: m0 write only, awaddr=0x10, wdata=0xA5A5A5A5, wstrb=0xF -> s_awvalid=1 in the same cycle; m0 awready=wready=1; a later m1 read of 0x10 returns 0xA5A5A5A5.
REQ-031 Bench SHALL cover: m0 and m1 both issue reads every cycle, RR_EN=1 -> grants alternate m0,m1,m0,m1, and each rvalid goes only to the owner.
REQ-032 Bench SHALL cover: the same contention with RR_EN=0 -> m1 never granted while m0 requests continuously.
REQ-033 Bench SHALL cover: m0 read with m0 rready held 0 for 5 cycles while m1 requests a write -> m1 wready stays 0 until the R handshake, then m1 is granted the next cycle.
REQ-034 Bench SHALL cover: m1 asserts awvalid, wvalid and arvalid together -> write first with wstrb=0x3 (only bytes 0..1 change), then the read in a later cycle returns the merged word.
REQ-035 Bench SHALL cover: rst_n pulsed low in RD_WAIT -> all outputs 0 asynchronously; after release, state=IDLE and a pending m1 request is granted when m0 is idle.
